// File: rtl/exu_mul_wb.sv
// exu_mul_wb -- multiplier writeback stage.
//
// Tracks the tag of every op accepted into a fixed 3-cycle multiplier,
// pairs it with the multiplier output when that output arrives, formats
// 32-bit ("word") results by sign-extension, and buffers the results in a
// small in-order queue that drains through a valid/ready writeback port.
//
// Handshakes (both ports): a transfer happens in a cycle where valid and
// ready are both 1 at the rising clock edge. The issue side is credit
// based: issue_ready is only raised when the queue has room for every op
// already in the multiplier plus the one being offered, so a result never
// has to stall. wb_tag/wb_data stay stable while wb_valid=1 and wb_ready=0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   issue_valid    op offered to the multiplier this cycle
//   issue_ready    block can accept an op this cycle
//   issue_tag      writeback tag of the offered op
//   issue_word     op is 32-bit; its result is sign-extended from bit 31
//   flush          kill every in-flight and queued op
//   mul_result     multiplier output, belongs to the op issued 3 cycles ago
//   wb_valid       queue head holds a result
//   wb_ready       writeback port consumes the head
//   wb_tag/wb_data head entry (zero while the queue is empty)

module exu_mul_wb #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 6,
  parameter int QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [TAG_WIDTH-1:0]  issue_tag,
  input  logic                  issue_word,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [TAG_WIDTH-1:0]  wb_tag,
  output logic [DATA_WIDTH-1:0] wb_data
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  // Wide enough for count plus three in-flight valids.
  localparam int SW = CW + 2;

  // Tag pipe, stage 1..3, aligned with the multiplier's latency.
  logic [3:1]           s_valid;
  logic [3:1]           s_word;
  logic [TAG_WIDTH-1:0] s_tag [3:1];

  // Result queue.
  logic [TAG_WIDTH-1:0]  q_tag  [QDEPTH];
  logic [DATA_WIDTH-1:0] q_data [QDEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  // Holds issue_ready low until the first clock edge after reset release.
  logic                  ready_en;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [SW-1:0]         occupancy;
  logic [DATA_WIDTH-1:0] fmt_data;

  // Queue entries plus ops still inside the multiplier; a same-cycle pop
  // gives no credit back.
  assign occupancy   = SW'(count) + SW'(s_valid[1]) + SW'(s_valid[2]) + SW'(s_valid[3]);
  assign issue_ready = ready_en & ~flush & (occupancy < SW'(QDEPTH));
  assign accept      = issue_valid & issue_ready & ~flush;
  assign push        = s_valid[3] & ~flush;
  assign pop         = wb_valid & wb_ready & ~flush;

  always_comb begin
    fmt_data = mul_result;
    if (s_word[3]) begin
      fmt_data = {{(DATA_WIDTH-32){mul_result[31]}}, mul_result[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Tag pipe advances every cycle; nothing downstream can stall it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= '0;
      s_word  <= '0;
      s_tag[1] <= '0;
      s_tag[2] <= '0;
      s_tag[3] <= '0;
    end else begin
      if (flush) begin
        s_valid <= '0;
      end else begin
        s_valid <= {s_valid[2:1], accept};
      end
      s_word   <= {s_word[2:1], issue_word};
      s_tag[1] <= issue_tag;
      s_tag[2] <= s_tag[1];
      s_tag[3] <= s_tag[2];
    end
  end

  // Queue storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_tag[wr_ptr]  <= s_tag[3];
      q_data[wr_ptr] <= fmt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign wb_valid = (count != '0);
  assign wb_tag   = wb_valid ? q_tag[rd_ptr]  : '0;
  assign wb_data  = wb_valid ? q_data[rd_ptr] : '0;

  // The issue credit scheme must make a push into a full queue impossible.
  always @(posedge clk) begin
    if (rst_n && push) begin
      a_no_overflow: assert (count != CW'(QDEPTH));
    end
  end

endmodule
